control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 32 +++
 rtl/pc_counter.sv | 21 ++
 rtl/control_sequencer.sv | 99 +++++++++
 tb/tb_control_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - state, opcode and ALU_Op encodings shared by the control sequencer
package control_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_EXEC  = 2'd2;
    localparam state_t ST_HALT  = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_CLRA = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       acc_en;
        logic       acc_clr;
        logic       out_en;
    } ctrl_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - 4-bit program counter, Load takes priority over Inc, wraps mod 16
module pc_counter (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       Inc,
    input  logic       Load,
    input  logic [3:0] D,
    output logic [3:0] Q
);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q <= 4'd0;
        end else if (Load) begin
            Q <= D;
        end else if (Inc) begin
            Q <= Q + 4'd1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - IDLE/FETCH/EXEC/HALT instruction sequencer for an 8-bit accumulator datapath
// Define SEQ_BRANCH_EN to enable JMP/JZ; otherwise opcodes 6 and 7 are NOPs and Zero is ignored.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       Start,
    input  logic [7:0] Instr,
    input  logic       Zero,
    output logic [3:0] Addr,
    output logic [3:0] Imm,
    output logic [1:0] ALU_Op,
    output logic       ACC_En,
    output logic       ACC_Clr,
    output logic       OUT_En,
    output logic       Busy,
    output logic       Halted
);

    state_t     state;
    state_t     state_next;
    logic [7:0] ir;
    logic [3:0] opcode;
    logic [3:0] pc;
    logic       pc_inc;
    logic       pc_load;
    ctrl_t      ctrl;

    assign opcode = ir[7:4];

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = Start ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC:  state_next = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
            default:  state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= ST_IDLE;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            if (state == ST_FETCH) begin
                ir <= Instr;
            end
        end
    end

    assign pc_inc = (state == ST_FETCH);

`ifdef SEQ_BRANCH_EN
    // Zero only steers the PC load, never an output.
    assign pc_load = (state == ST_EXEC) &&
                     ((opcode == OP_JMP) || ((opcode == OP_JZ) && Zero));
`else
    logic unused_zero;
    assign unused_zero = Zero;
    assign pc_load     = 1'b0;
`endif

    pc_counter u_pc (
        .CLK  (CLK),
        .CLR  (CLR),
        .Inc  (pc_inc),
        .Load (pc_load),
        .D    (ir[3:0]),
        .Q    (pc)
    );

    always_comb begin
        ctrl = '0;
        if (state == ST_EXEC) begin
            case (opcode)
                OP_LDI:  begin ctrl.acc_en = 1'b1; ctrl.alu_op = ALU_PASS; end
                OP_ADDI: begin ctrl.acc_en = 1'b1; ctrl.alu_op = ALU_ADD;  end
                OP_SUBI: begin ctrl.acc_en = 1'b1; ctrl.alu_op = ALU_SUB;  end
                OP_CLRA: ctrl.acc_clr = 1'b1;
                OP_OUT:  ctrl.out_en  = 1'b1;
                OP_NOP, OP_JMP, OP_JZ, OP_HLT: ctrl = '0;
                default: ctrl = '0;
            endcase
        end
    end

    assign Addr    = pc;
    assign Imm     = ir[3:0];
    assign ALU_Op  = ctrl.alu_op;
    assign ACC_En  = ctrl.acc_en;
    assign ACC_Clr = ctrl.acc_clr;
    assign OUT_En  = ctrl.out_en;
    assign Busy    = (state == ST_FETCH) || (state == ST_EXEC);
    assign Halted  = (state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer against an instruction-level model
module tb_control_sequencer;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       Start;
    logic [7:0] Instr;
    logic       Zero;
    logic [3:0] Addr;
    logic [3:0] Imm;
    logic [1:0] ALU_Op;
    logic       ACC_En;
    logic       ACC_Clr;
    logic       OUT_En;
    logic       Busy;
    logic       Halted;

    control_sequencer dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .Start   (Start),
        .Instr   (Instr),
        .Zero    (Zero),
        .Addr    (Addr),
        .Imm     (Imm),
        .ALU_Op  (ALU_Op),
        .ACC_En  (ACC_En),
        .ACC_Clr (ACC_Clr),
        .OUT_En  (OUT_En),
        .Busy    (Busy),
        .Halted  (Halted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] imm;
        logic [1:0] alu;
        logic       acc_en;
        logic       acc_clr;
        logic       out_en;
        logic       busy;
        logic       halted;
    } rec_t;

    logic [7:0] prog [16];
    bit         zero_cyc [64];
    rec_t       exp_q [$];
    rec_t       got_r;
    rec_t       exp_r;
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;

    assign Instr = prog[Addr];

    function automatic rec_t dut_rec();
        return rec_t'({Addr, Imm, ALU_Op, ACC_En, ACC_Clr, OUT_En, Busy, Halted});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every active cycle must match the next predicted cycle.
    always @(negedge CLK) begin
        if (mon_en && (Busy || Halted)) begin
            got_r = dut_rec();
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_cycle: got=%h expected=none", got_r);
            end else begin
                exp_r = exp_q.pop_front();
                if (got_r !== exp_r) begin
                    fails++;
                    $display("FAIL cycle_rec t=%0t: got=%h expected=%h", $time, got_r, exp_r);
                end
            end
        end
    end

    // Instruction-level model: one fetch step then one execute step per instruction.
    // zmode: 0 random Zero, 1 Zero always high, 2 Zero always low.
    task automatic build(input int n, input int zmode);
        int         pc;
        int         phase;
        logic [7:0] ir;
        logic [3:0] op;
        rec_t       r;
        pc = 0;
        ir = 8'h00;
        phase = 0;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            zero_cyc[c] = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            r = '0;
            if (phase == 0) begin
                r.addr = 4'(pc);
                r.imm  = ir[3:0];
                r.busy = 1'b1;
                ir     = prog[pc];
                pc     = (pc + 1) % 16;
                phase  = 1;
            end else if (phase == 1) begin
                r.addr = 4'(pc);
                r.imm  = ir[3:0];
                r.busy = 1'b1;
                op     = ir[7:4];
                case (op)
                    4'h1: begin r.acc_en = 1'b1; r.alu = 2'b00; end
                    4'h2: begin r.acc_en = 1'b1; r.alu = 2'b01; end
                    4'h3: begin r.acc_en = 1'b1; r.alu = 2'b10; end
                    4'h4: r.acc_clr = 1'b1;
                    4'h5: r.out_en  = 1'b1;
                    default: ;
                endcase
`ifdef SEQ_BRANCH_EN
                if (op == 4'h6 || (op == 4'h7 && zero_cyc[c])) pc = int'(ir[3:0]);
`endif
                phase = (op == 4'hF) ? 2 : 0;
            end else begin
                r.addr   = 4'(pc);
                r.imm    = ir[3:0];
                r.halted = 1'b1;
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic do_reset();
        CLR   = 1'b0;
        Start = 1'b0;
        Zero  = 1'b0;
        #1;
        check("reset_outputs", 32'(dut_rec()), 32'h0);
        repeat (2) @(posedge CLK);
        #1 CLR = 1'b1;
    endtask

    task automatic run(input int n, input int zmode);
        build(n, zmode);
        @(posedge CLK);
        #1 Start = 1'b1;
        @(posedge CLK);
        mon_en = 1'b1;
        for (int c = 0; c < n; c++) begin
            #1;
            Zero  = zero_cyc[c];
            Start = 1'($urandom_range(0, 1));
            @(posedge CLK);
        end
        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        do_reset();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    initial begin
        clear_prog();
        CLR   = 1'b0;
        Start = 1'b0;
        Zero  = 1'b0;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle_hold", 32'(dut_rec()), 32'h0);
        end

        clear_prog();
        prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h50; prog[3] = 8'hF0;
        run(16, 0);

        clear_prog();
        prog[15] = 8'h60;
        run(40, 0);

        clear_prog();
        prog[0] = 8'h7A; prog[10] = 8'hF0; prog[2] = 8'hF0;
        run(10, 1);
        run(10, 2);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
            run(int'($urandom_range(20, 50)), 0);
        end

        clear_prog();
        prog[0] = 8'h15;
        @(posedge CLK);
        #1 Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (ACC_En) break;
        end
        check("midexec_reached", 32'(ACC_En), 32'd1);
        CLR = 1'b0;
        #1;
        check("midexec_acc_en", 32'(ACC_En), 32'd0);
        check("midexec_addr", 32'(Addr), 32'd0);
        check("midexec_busy", 32'(Busy), 32'd0);
        check("midexec_halted", 32'(Halted), 32'd0);
        @(posedge CLK);
        #1 CLR = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("post_reset_idle", 32'(dut_rec()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
